// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multicycle controller and its datapath
interface multicycle_control_if;
    logic [5:0] opcode_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic [1:0] pc_src_o;
    logic       iord_o;
    logic       ir_write_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       reg_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic       bus_error_o;
    logic [3:0] state_o;

    modport master (
        input  opcode_i, zero_i, mem_ready_i,
        output pc_write_o, pc_src_o, iord_o, ir_write_o, mem_read_o, mem_write_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, instr_done_o, illegal_o, bus_error_o, state_o
    );

    modport slave (
        output opcode_i, zero_i, mem_ready_i,
        input  pc_write_o, pc_src_o, iord_o, ir_write_o, mem_read_o, mem_write_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, instr_done_o, illegal_o, bus_error_o, state_o
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory wait-state timeout
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        EXEC_I    = 4'd8,
        ALU_WB    = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        FAULT     = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       bus_error;

    // A ready on the limit cycle still wins, so the fault is only taken without ready.
    assign timeout = (wait_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        instr_done = 1'b0;
        illegal    = 1'b0;
        bus_error  = 1'b0;

        // Outputs are forced low while reset is held so no request survives it.
        if (reset) begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 3'b100;
                    ir_write  = bus.mem_ready_i;
                    pc_write  = bus.mem_ready_i;
                    if (bus.mem_ready_i)  state_d = DECODE;
                    else if (timeout)     state_d = FAULT;
                    else                  wait_d  = wait_q + 8'd1;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = 3'b100;
                    case (bus.opcode_i)
                        OP_LW, OP_SW:             state_d = MEM_ADDR;
                        OP_R:                     state_d = EXEC_R;
                        OP_ADDI, OP_ORI, OP_LUI:  state_d = EXEC_I;
                        OP_BEQ, OP_BNE:           state_d = BRANCH;
                        OP_J:                     state_d = JUMP;
                        default: begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 3'b100;
                    state_d   = (bus.opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (bus.mem_ready_i)  state_d = MEM_WB;
                    else if (timeout)     state_d = FAULT;
                    else                  wait_d  = wait_q + 8'd1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (bus.mem_ready_i) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else if (timeout) begin
                        state_d = FAULT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b111;
                    state_d   = ALU_WB;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (bus.opcode_i)
                        OP_ORI:  alu_op = 3'b010;
                        OP_LUI:  alu_op = 3'b001;
                        default: alu_op = 3'b100;
                    endcase
                    state_d = ALU_WB;
                end
                ALU_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (bus.opcode_i == OP_R);
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 3'b011;
                    pc_src     = 2'b01;
                    pc_write   = ((bus.opcode_i == OP_BEQ) &  bus.zero_i) |
                                 ((bus.opcode_i == OP_BNE) & ~bus.zero_i);
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                FAULT:   bus_error = 1'b1;
                default: state_d = IDLE;
            endcase

            if (state_q != FAULT && (bus.mem_ready_i ||
                (state_d != state_q &&
                 (state_d == FETCH || state_d == MEM_READ || state_d == MEM_WRITE)))) begin
                wait_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.pc_write_o   = pc_write;
    assign bus.pc_src_o     = pc_src;
    assign bus.iord_o       = iord;
    assign bus.ir_write_o   = ir_write;
    assign bus.mem_read_o   = mem_read;
    assign bus.mem_write_o  = mem_write;
    assign bus.reg_write_o  = reg_write;
    assign bus.reg_dst_o    = reg_dst;
    assign bus.mem_to_reg_o = mem_to_reg;
    assign bus.alu_src_a_o  = alu_src_a;
    assign bus.alu_src_b_o  = alu_src_b;
    assign bus.alu_op_o     = alu_op;
    assign bus.instr_done_o = instr_done;
    assign bus.illegal_o    = illegal;
    assign bus.bus_error_o  = bus_error;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    localparam int TMO = 4;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if bus();

    multicycle_control #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic [18:0] outs;
    } vec_t;

    vec_t tab[$];

    function automatic logic [18:0] pack_outs();
        return {bus.pc_write_o, bus.pc_src_o, bus.iord_o, bus.ir_write_o, bus.mem_read_o,
                bus.mem_write_o, bus.reg_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
                bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.instr_done_o,
                bus.illegal_o, bus.bus_error_o};
    endfunction

    function automatic vec_t v(input logic [5:0] op, input logic zero, input logic [3:0] st,
                               input logic pcw, input logic [1:0] pcs, input logic iord,
                               input logic irw, input logic mr, input logic mw, input logic rw,
                               input logic rd, input logic m2r, input logic asa,
                               input logic [1:0] asb, input logic [2:0] aop,
                               input logic done, input logic ill);
        vec_t r;
        r.op   = op;
        r.zero = zero;
        r.st   = st;
        r.outs = {pcw, pcs, iord, irw, mr, mw, rw, rd, m2r, asa, asb, aop, done, ill, 1'b0};
        return r;
    endfunction

    function automatic vec_t v_fetch(input logic [5:0] op, input logic zero);
        return v(op, zero, 4'd1, 1, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 3'b100, 0, 0);
    endfunction

    function automatic vec_t v_dec(input logic [5:0] op, input logic zero);
        return v(op, zero, 4'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b100, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Instruction-level reference: latency and per-instruction event counts from the ISA rules.
    function automatic int base_latency(input logic [5:0] op);
        case (op)
            6'h00, 6'h08, 6'h0D, 6'h0F: return 4;
            6'h23:                      return 5;
            6'h2B:                      return 4;
            6'h04, 6'h05, 6'h02:        return 3;
            default:                    return 2;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic zero, input int fw, input int mw);
        int  fc = 0, dc = 0, cyc = 0;
        int  rw_n = 0, mwc_n = 0, pcw_n = 0, ill_n = 0;
        int  wb_rd = 0, wb_m2r = 0;
        bit  done = 0;
        bit  is_mem = (op == 6'h23) || (op == 6'h2B);
        bit  writes = (op == 6'h00) || (op == 6'h08) || (op == 6'h0D) || (op == 6'h0F) || (op == 6'h23);
        bit  taken = (op == 6'h02) || (op == 6'h04 && zero) || (op == 6'h05 && !zero);
        bit  legal = base_latency(op) != 2;
        bus.opcode_i = op;
        bus.zero_i   = zero;
        #1 chk("rand_start_state", bus.state_o, 4'd1);
        while (!done && cyc < 40) begin
            if (bus.mem_read_o || bus.mem_write_o) begin
                if (!bus.iord_o) begin bus.mem_ready_i = (fc == fw); fc++; end
                else             begin bus.mem_ready_i = (dc == mw); dc++; end
            end else begin
                bus.mem_ready_i = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            if (bus.reg_write_o) begin
                rw_n++;
                wb_rd  = bus.reg_dst_o;
                wb_m2r = bus.mem_to_reg_o;
            end
            if (bus.mem_write_o) mwc_n++;
            if (bus.pc_write_o)  pcw_n++;
            if (bus.illegal_o)   ill_n++;
            if (bus.instr_done_o) done = 1;
            @(negedge clk);
        end
        chk("rand_cycles", cyc, base_latency(op) + fw + (is_mem ? mw : 0));
        chk("rand_reg_writes", rw_n, writes ? 1 : 0);
        chk("rand_mem_write_cycles", mwc_n, (op == 6'h2B) ? mw + 1 : 0);
        chk("rand_pc_writes", pcw_n, taken ? 2 : 1);
        chk("rand_illegal", ill_n, legal ? 0 : 1);
        if (writes) chk("rand_wb_sel", {wb_rd[0], wb_m2r[0]}, {op == 6'h00, op == 6'h23});
    endtask

    logic [5:0] ops [11] = '{6'h00, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};

    initial begin
        reset           = 1'b0;
        bus.opcode_i    = 6'h00;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b1;

        tab.push_back(v(6'h08, 0, 4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0));
        tab.push_back(v_fetch(6'h08, 0));
        tab.push_back(v_dec(6'h08, 0));
        tab.push_back(v(6'h08, 0, 4'd8, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 0, 0));
        tab.push_back(v(6'h08, 0, 4'd9, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 1, 0));
        tab.push_back(v_fetch(6'h00, 0));
        tab.push_back(v_dec(6'h00, 0));
        tab.push_back(v(6'h00, 0, 4'd7, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 0, 0));
        tab.push_back(v(6'h00, 0, 4'd9, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 1, 0));
        tab.push_back(v_fetch(6'h0D, 0));
        tab.push_back(v_dec(6'h0D, 0));
        tab.push_back(v(6'h0D, 0, 4'd8, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0, 0));
        tab.push_back(v(6'h0D, 0, 4'd9, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 1, 0));
        tab.push_back(v_fetch(6'h0F, 0));
        tab.push_back(v_dec(6'h0F, 0));
        tab.push_back(v(6'h0F, 0, 4'd8, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b001, 0, 0));
        tab.push_back(v(6'h0F, 0, 4'd9, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 1, 0));
        tab.push_back(v_fetch(6'h04, 1));
        tab.push_back(v_dec(6'h04, 1));
        tab.push_back(v(6'h04, 1, 4'd10, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b011, 1, 0));
        tab.push_back(v_fetch(6'h05, 1));
        tab.push_back(v_dec(6'h05, 1));
        tab.push_back(v(6'h05, 1, 4'd10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b011, 1, 0));
        tab.push_back(v_fetch(6'h02, 0));
        tab.push_back(v_dec(6'h02, 0));
        tab.push_back(v(6'h02, 0, 4'd11, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0));
        tab.push_back(v_fetch(6'h3F, 0));
        tab.push_back(v(6'h3F, 0, 4'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b100, 1, 1));
        tab.push_back(v_fetch(6'h2B, 0));
        tab.push_back(v_dec(6'h2B, 0));
        tab.push_back(v(6'h2B, 0, 4'd3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 0, 0));
        tab.push_back(v(6'h2B, 0, 4'd6, 0, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0));
        tab.push_back(v_fetch(6'h23, 0));
        tab.push_back(v_dec(6'h23, 0));
        tab.push_back(v(6'h23, 0, 4'd3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 0, 0));
        tab.push_back(v(6'h23, 0, 4'd4, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0));
        tab.push_back(v(6'h23, 0, 4'd5, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 1, 0));
        tab.push_back(v_fetch(6'h23, 0));

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", bus.state_o, 4'd0);
        chk("reset_outs", pack_outs(), 19'd0);

        @(negedge clk);
        reset = 1'b1;
        foreach (tab[i]) begin
            bus.opcode_i    = tab[i].op;
            bus.zero_i      = tab[i].zero;
            bus.mem_ready_i = 1'b1;
            #1;
            chk($sformatf("vec%0d_state", i), bus.state_o, tab[i].st);
            chk($sformatf("vec%0d_outs", i), pack_outs(), tab[i].outs);
            @(negedge clk);
        end

        // LW with three wait cycles in MEM_READ
        do_reset();
        begin
            int cyc = 0;
            bus.opcode_i = 6'h23; bus.mem_ready_i = 1'b1;
            #1 cyc++; @(negedge clk);
            #1 cyc++; @(negedge clk);
            #1 cyc++; @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                bus.mem_ready_i = (k == 3);
                #1 cyc++;
                chk("lw_wait_state", bus.state_o, 4'd4);
                chk("lw_wait_req", {bus.mem_read_o, bus.iord_o}, 2'b11);
                @(negedge clk);
            end
            bus.mem_ready_i = 1'b1;
            #1 cyc++;
            chk("lw_wb", {bus.state_o, bus.reg_write_o, bus.mem_to_reg_o, bus.reg_dst_o, bus.instr_done_o},
                {4'd5, 1'b1, 1'b1, 1'b0, 1'b1});
            chk("lw_cycles", cyc, 8);
            @(negedge clk);
        end

        // SW with ready on exactly the last allowed wait cycle
        do_reset();
        bus.opcode_i = 6'h2B; bus.mem_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < TMO; k++) begin
            bus.mem_ready_i = (k == TMO - 1);
            #1 chk("sw_edge_state", bus.state_o, 4'd6);
            if (k == TMO - 1) chk("sw_edge_done", bus.instr_done_o, 1'b1);
            @(negedge clk);
        end
        #1 chk("sw_edge_no_fault", {bus.state_o, bus.bus_error_o}, {4'd1, 1'b0});

        // SW never ready: timeout into FAULT
        do_reset();
        bus.opcode_i = 6'h2B; bus.mem_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_ready_i = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            #1 chk("sw_tmo_state", {bus.state_o, bus.mem_write_o}, {4'd6, 1'b1});
            @(negedge clk);
        end
        #1 chk("fault_entry", {bus.state_o, pack_outs()}, {4'd12, 19'd1});
        bus.mem_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("fault_sticky", {bus.state_o, pack_outs()}, {4'd12, 19'd1});
        #2 reset = 1'b0;
        #1 chk("fault_reset", {bus.state_o, pack_outs()}, {4'd0, 19'd0});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of EXEC_R
        bus.opcode_i = 6'h00; bus.mem_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("execr_state", bus.state_o, 4'd7);
        #2 reset = 1'b0;
        #1 chk("execr_async_reset", {bus.state_o, pack_outs()}, {4'd0, 19'd0});

        do_reset();
        for (int n = 0; n < 60; n++) begin
            run_instr(ops[$urandom_range(0, 10)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory access and writeback, over a shared instruction/data memory.
- Memory access uses a ready handshake with a wait-state timeout.
- Sits beside the register file, ALU and memory; drives every datapath enable and mux select.
- Opcodes handled: R-type 0x00, ADDI 0x08, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02.

Parameters:
- TIMEOUT_CYCLES, 15: maximum wait cycles for mem_ready_i in any memory state before bus fault (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode_i  in  6  opcode from the instruction register; stable after FETCH.
- zero_i  in  1  ALU zero flag, valid in BRANCH.
- mem_ready_i  in  1  memory completed the current read/write this cycle.
- pc_write_o  out  1  PC load enable.
- pc_src_o  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump address.
- iord_o  out  1  memory address select: 0 PC, 1 ALUOut.
- ir_write_o  out  1  instruction register load.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  1  destination: 1 rd, 0 rt.
- mem_to_reg_o  out  1  write-back data: 1 MDR, 0 ALUOut.
- alu_src_a_o  out  1  ALU A: 0 PC, 1 rs.
- alu_src_b_o  out  2  ALU B: 00 rt, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op_o  out  3  111 R-type (funct), 100 add, 011 subtract, 010 or, 001 lui.
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_o  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- bus_error_o  out  1  sticky: memory timeout occurred.
- state_o  out  4  current state encoding (debug).

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, JUMP=11, FAULT=12.
- Reset asserted: state=IDLE and wait counter=0. All outputs are 0 (alu_op_o=000, pc_src_o=00, alu_src_b_o=00).
- IDLE → FETCH unconditionally on the first clock after reset release.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=100.
  - ir_write_o and pc_write_o (pc_src_o=00) equal mem_ready_i (Mealy).
  - On ready → DECODE; otherwise stay.
- DECODE:
  - alu_src_a_o=0, alu_src_b_o=11, alu_op_o=100 (branch target precomputed into ALUOut).
  - Next state: LW/SW → MEM_ADDR; R → EXEC_R; ADDI/ORI/LUI → EXEC_I; BEQ/BNE → BRANCH; J → JUMP.
  - Any other opcode: illegal_o=1, instr_done_o=1, → FETCH. The instruction is a NOP; PC has already advanced.
- MEM_ADDR:
  - alu_src_a_o=1, alu_src_b_o=10, alu_op_o=100.
  - LW → MEM_READ; SW → MEM_WRITE.
- MEM_READ: mem_read_o=1, iord_o=1; on ready → MEM_WB.
- MEM_WB: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0, instr_done_o=1; → FETCH.
- MEM_WRITE: mem_write_o=1, iord_o=1; on ready: instr_done_o=1, → FETCH.
- EXEC_R: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=111; → ALU_WB.
- EXEC_I: alu_src_a_o=1, alu_src_b_o=10, alu_op_o = 100 (ADDI), 010 (ORI), 001 (LUI); → ALU_WB.
- ALU_WB: reg_write_o=1, mem_to_reg_o=0, reg_dst_o=(opcode_i==0); instr_done_o=1; → FETCH.
- BRANCH:
  - alu_src_a_o=1, alu_src_b_o=00, alu_op_o=011, pc_src_o=01.
  - pc_write_o = (BEQ & zero_i) | (BNE & ~zero_i).
  - instr_done_o=1; → FETCH.
- JUMP: pc_write_o=1, pc_src_o=10, instr_done_o=1; → FETCH.
- Latency: R/I-type 4 cycles; LW 5; SW 4; branch 3; J 3. Each memory state adds 1 cycle per wait cycle.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE, and when mem_ready_i=1.
  - Increments each cycle a memory state sees mem_ready_i=0.
  - When it reaches TIMEOUT_CYCLES with no ready → FAULT.
  - A ready in the same cycle the count hits the limit wins: normal transition, no fault.
- FAULT: terminal until reset. bus_error_o=1, all other outputs 0, no memory requests, mem_ready_i ignored.
- mem_ready_i outside memory states is ignored.
- Reset mid-instruction: immediate return to IDLE; any pending memory request is dropped combinationally.

Test Plan:
- Reset, ready tied 1, ADDI (0x08): states 0,1,2,8,9,1; alu_op_o=100 in EXEC_I; reg_write_o=1, reg_dst_o=0 in ALU_WB; instr_done_o pulses at cycle 4.
- LW with 3 wait cycles in MEM_READ: MEM_READ held 4 cycles with mem_read_o=1 and iord_o=1; MEM_WB has mem_to_reg_o=1; total 8 cycles.
- BEQ with zero_i=1 → pc_write_o=1, pc_src_o=01. BNE with zero_i=1 → pc_write_o=0. Both retire in 3 cycles.
- Opcode 0x3F: illegal_o single pulse in DECODE, back to FETCH, no reg_write_o or mem_write_o.
- TIMEOUT_CYCLES=4, SW with ready never asserted: FAULT after 4 MEM_WRITE cycles; bus_error_o=1 and stays 1 under further ready; reset clears it to 0 and state_o=0.
- Ready arriving on exactly the 4th wait cycle: no fault, normal transition. Reset asserted mid-EXEC_R: all outputs 0 asynchronously, state_o=0.
